mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the fetch stage (F) and the data-memory stage (M).

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_watchdog.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    // Wide enough for byte enables of any data width up to 512 bits; sliced by users.
    localparam int                    BE_MAX_W = 64;
    localparam logic [BE_MAX_W-1:0]   BE_ALL   = {BE_MAX_W{1'b1}};

endpackage

// File: rtl/mem_arb_watchdog.sv
// Memory-latency watchdog: counts cycles a request waits without ack and raises a sticky error.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ack,
    output logic bus_err
);

    localparam int             CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             bus_err_r;

    // Next count: clear on ack, count waiting cycles, saturate at the limit.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (ack) begin
            cnt_nxt_s = '0;
        end else if (busy && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + 1'b1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and sticky error register; bus_err rises on the edge the limit is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            bus_err_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            bus_err_r <= bus_err_r | (cnt_nxt_s == CNT_MAX);
        end
    end

    assign bus_err = bus_err_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data stages; data always wins,
// killed fetches are drained and discarded.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                f_stall,
    output logic                m_stall,
    output logic                bus_err
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;

    logic              dm_elig_s;
    logic              f_elig_s;
    logic              grant_dm_s;
    logic              grant_f_s;
    logic              mem_done_s;
    logic              fetch_done_s;
    logic              data_done_s;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [BE_W-1:0]   mem_be_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic              if_valid_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              dm_valid_r;

    // A requester whose valid pulse is out this cycle is still holding the old request.
    assign dm_elig_s = dm_req & ~dm_valid_r;
    assign f_elig_s  = if_req & ~if_valid_r & ~if_kill;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, grant and completion decode.
    always_comb begin
        state_nxt_s  = state_r;
        grant_dm_s   = 1'b0;
        grant_f_s    = 1'b0;
        mem_done_s   = 1'b0;
        fetch_done_s = 1'b0;
        data_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (dm_elig_s) begin
                    state_nxt_s = DATA;
                    grant_dm_s  = 1'b1;
                end else if (f_elig_s) begin
                    state_nxt_s = FETCH;
                    grant_f_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    mem_done_s   = 1'b1;
                    fetch_done_s = ~if_kill;
                    state_nxt_s  = IDLE;
                end else if (if_kill) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    mem_done_s  = 1'b1;
                    data_done_s = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    mem_done_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Memory request and payload: latched at grant, held stable until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_be_r    <= '0;
        end else if (grant_dm_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= dm_we;
            mem_addr_r  <= dm_addr;
            mem_wdata_r <= dm_wdata;
            mem_be_r    <= dm_be;
        end else if (grant_f_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= if_addr;
            mem_wdata_r <= '0;
            mem_be_r    <= BE_ALL[BE_W-1:0];
        end else if (mem_done_s) begin
            mem_req_r   <= 1'b0;
        end
    end

    // Read-data capture and one-cycle completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_r <= '0;
            if_valid_r <= 1'b0;
            dm_rdata_r <= '0;
            dm_valid_r <= 1'b0;
        end else begin
            if_valid_r <= fetch_done_s;
            dm_valid_r <= data_done_s;
            if (fetch_done_s) begin
                if_rdata_r <= mem_rdata;
            end
            if (data_done_s) begin
                dm_rdata_r <= mem_rdata;
            end
        end
    end

    mem_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .busy    (mem_req_r),
        .ack     (mem_ack & mem_req_r),
        .bus_err (bus_err)
    );

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign if_rdata  = if_rdata_r;
    assign if_valid  = if_valid_r;
    assign dm_rdata  = dm_rdata_r;
    assign dm_valid  = dm_valid_r;
    assign f_stall   = if_req & ~if_valid_r;
    assign m_stall   = dm_req & ~dm_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a memory-content reference model and a behavioural memory slave.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, if_kill = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [3:0]    dm_be = 4'h0;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic          if_valid, dm_valid, mem_req, mem_we, mem_ack, f_stall, m_stall, bus_err;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .f_stall(f_stall), .m_stall(m_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference memory (updated from what the bench asked for) and the slave's own memory
    // (updated from what the DUT put on the bus).
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] sl_mem  [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] sl_read(input logic [31:0] a);
        if (sl_mem.exists(a)) return sl_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ref_mem[a] = d;
        sl_mem[a]  = d;
    endtask

    // Memory slave: acks cur_lat cycles after mem_req rises; garbage on rdata otherwise.
    bit   slave_auto = 1'b1;
    bit   slave_rand = 1'b0;
    int   slave_lat  = 0;
    int   cur_lat    = 0;
    int   wait_cnt   = 0;
    logic prev_req_sl = 1'b0;

    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req && !prev_req_sl) cur_lat = slave_rand ? $urandom_range(3, 0) : slave_lat;
        if (mem_req && slave_auto) begin
            if (wait_cnt >= cur_lat) begin
                mem_ack = 1'b1;
                if (mem_we) sl_mem[mem_addr] = merge(sl_read(mem_addr), mem_wdata, mem_be);
                mem_rdata = sl_read(mem_addr);
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else if (!mem_req) begin
            wait_cnt = 0;
        end
        prev_req_sl = mem_req;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if ({mem_we, mem_addr, mem_wdata, mem_be} !== 69'h0) $display("FAIL reset_payload: got %h want 0", {mem_we, mem_addr, mem_wdata, mem_be}); else n_pass++;
        n_checks++; if ({if_valid, dm_valid} !== 2'b00) $display("FAIL reset_valids: got %b want 00", {if_valid, dm_valid}); else n_pass++;
        n_checks++; if ({if_rdata, dm_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h want 0", {if_rdata, dm_rdata}); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (dut.state_r !== IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state_r, IDLE); else n_pass++;
    endtask

    task automatic test_fetch();
        int  vt;
        bit  seen;
        vt = -1; seen = 1'b0;
        slave_lat = 1;
        preload(32'h100, 32'h0050_0093);
        if_addr = 32'h100; if_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            // Grant, one waiting cycle, ack cycle, then the valid cycle at k == 3.
            n_checks++; if (f_stall !== ((k < 3) ? 1'b1 : 1'b0)) $display("FAIL fetch_f_stall k=%0d: got %b want %b", k, f_stall, (k < 3)); else n_pass++;
            if (mem_req && !seen) begin
                seen = 1'b1;
                n_checks++; if ({mem_we, mem_addr, mem_be} !== {1'b0, 32'h100, 4'hF}) $display("FAIL fetch_bus: got %h want %h", {mem_we, mem_addr, mem_be}, {1'b0, 32'h100, 4'hF}); else n_pass++;
            end
            if (if_valid) begin
                vt = k;
                n_checks++; if (if_rdata !== 32'h0050_0093) $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); else n_pass++;
                if_req = 1'b0;
                break;
            end
        end
        n_checks++; if (vt !== 3) $display("FAIL fetch_latency: got %0d want 3", vt); else n_pass++;
        tick();
        n_checks++; if ({if_valid, f_stall} !== 2'b00) $display("FAIL fetch_pulse: got %b want 00", {if_valid, f_stall}); else n_pass++;
    endtask

    task automatic test_priority();
        int dmv, fgrant, fv;
        dmv = -1; fgrant = -1; fv = -1;
        slave_lat = 0;
        preload(32'h200, 32'h1357_9BDF);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h200;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                n_checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h2000}) $display("FAIL prio_first_grant: got %h want %h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 32'h2000}); else n_pass++;
            end
            if (mem_req && !mem_we && fgrant < 0) begin
                fgrant = k;
                n_checks++; if (mem_addr !== 32'h200) $display("FAIL prio_fetch_addr: got %h want 200", mem_addr); else n_pass++;
            end
            if (dm_valid) begin
                dmv = k;
                ref_mem[32'h2000] = merge(ref_read(32'h2000), 32'hDEAD_BEEF, 4'hF);
                dm_req = 1'b0; dm_we = 1'b0;
            end
            if (if_valid) begin
                fv = k;
                n_checks++; if (if_rdata !== ref_read(32'h200)) $display("FAIL prio_fetch_rdata: got %h want %h", if_rdata, ref_read(32'h200)); else n_pass++;
                if_req = 1'b0;
                break;
            end
        end
        n_checks++; if (dmv !== 2) $display("FAIL prio_dm_valid_cycle: got %0d want 2", dmv); else n_pass++;
        n_checks++; if (fgrant !== 3) $display("FAIL prio_fetch_after_dm: got %0d want 3", fgrant); else n_pass++;
        n_checks++; if (fv !== 4) $display("FAIL prio_fetch_valid_cycle: got %0d want 4", fv); else n_pass++;
        tick();
    endtask

    task automatic test_kill();
        int dgrant, dmv;
        bit saw_fv;
        dgrant = -1; dmv = -1; saw_fv = 1'b0;
        slave_lat = 3;
        if_addr = 32'h300; if_req = 1'b1;
        tick();
        n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) $display("FAIL kill_fetch_grant: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h300}); else n_pass++;
        if_kill = 1'b1; if_req = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        for (int k = 2; k <= 30; k++) begin
            tick();
            if (k == 2) begin
                n_checks++; if (dut.state_r !== DRAIN) $display("FAIL kill_state: got %0d want %0d", dut.state_r, DRAIN); else n_pass++;
                if_kill = 1'b0;
            end
            if (k <= 4) begin
                n_checks++; if (mem_req !== 1'b1) $display("FAIL kill_drain_req k=%0d: got %b want 1", k, mem_req); else n_pass++;
            end
            if (if_valid) saw_fv = 1'b1;
            if (mem_req && mem_addr == 32'h2000 && dgrant < 0) dgrant = k;
            if (dm_valid) begin
                dmv = k;
                n_checks++; if (dm_rdata !== ref_read(32'h2000)) $display("FAIL kill_dm_rdata: got %h want %h", dm_rdata, ref_read(32'h2000)); else n_pass++;
                dm_req = 1'b0;
                break;
            end
        end
        n_checks++; if (saw_fv !== 1'b0) $display("FAIL kill_no_if_valid: got %b want 0", saw_fv); else n_pass++;
        // Ack in cycle 4, IDLE grant in 5, mem_req in 6, ack in 9, dm_valid in 10.
        n_checks++; if (dgrant !== 6) $display("FAIL kill_dm_grant: got %0d want 6", dgrant); else n_pass++;
        n_checks++; if (dmv !== 10) $display("FAIL kill_dm_valid: got %0d want 10", dmv); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int v1, v2, cnt40;
        v1 = -1; v2 = -1; cnt40 = 0;
        slave_lat = 0;
        preload(32'h40, 32'hA0A0_0040);
        preload(32'h44, 32'hB0B0_0044);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (mem_req && mem_addr == 32'h40) cnt40++;
            if (dm_valid) begin
                if (v1 < 0) begin
                    v1 = k;
                    n_checks++; if (dm_rdata !== 32'hA0A0_0040) $display("FAIL b2b_rdata0: got %h want a0a00040", dm_rdata); else n_pass++;
                    dm_addr = 32'h44;
                end else begin
                    v2 = k;
                    n_checks++; if (dm_rdata !== 32'hB0B0_0044) $display("FAIL b2b_rdata1: got %h want b0b00044", dm_rdata); else n_pass++;
                    dm_req = 1'b0;
                    break;
                end
            end
        end
        n_checks++; if (v1 !== 2) $display("FAIL b2b_first_valid: got %0d want 2", v1); else n_pass++;
        n_checks++; if (v2 - v1 !== 3) $display("FAIL b2b_spacing: got %0d want 3", v2 - v1); else n_pass++;
        n_checks++; if (cnt40 !== 1) $display("FAIL b2b_dup_req: got %0d want 1", cnt40); else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        int  first;
        bit  got;
        first = -1; got = 1'b0;
        slave_auto = 1'b0; slave_lat = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2004;
        for (int k = 1; k <= TO + 5; k++) begin
            tick();
            if (bus_err && first < 0) first = k;
            if (k == TO) begin
                n_checks++; if (m_stall !== 1'b1) $display("FAIL timeout_m_stall: got %b want 1", m_stall); else n_pass++;
            end
        end
        // mem_req rises at tick 1, so the error appears TO cycles later.
        n_checks++; if (first !== TO + 1) $display("FAIL timeout_bus_err_cycle: got %0d want %0d", first, TO + 1); else n_pass++;
        slave_auto = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (dm_valid) begin
                got = 1'b1;
                n_checks++; if (dm_rdata !== ref_read(32'h2004)) $display("FAIL timeout_rdata: got %h want %h", dm_rdata, ref_read(32'h2004)); else n_pass++;
                dm_req = 1'b0;
                break;
            end
        end
        n_checks++; if (got !== 1'b1) $display("FAIL timeout_completion: got %b want 1", got); else n_pass++;
        tick();
        n_checks++; if (bus_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", bus_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit saw_dv;
        saw_dv = 1'b0;
        slave_lat = 5;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2008; dm_wdata = 32'h1122_3344; dm_be = 4'hF;
        tick(); tick();
        n_checks++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL rstmid_pre: got %b want 11", {mem_req, mem_we}); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if ({mem_req, bus_err} !== 2'b00) $display("FAIL rstmid_immediate: got %b want 00", {mem_req, bus_err}); else n_pass++;
        dm_req = 1'b0; dm_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (dm_valid) saw_dv = 1'b1;
        end
        rst = 1'b0;
        tick();
        if (dm_valid) saw_dv = 1'b1;
        n_checks++; if (saw_dv !== 1'b0) $display("FAIL rstmid_no_dm_valid: got %b want 0", saw_dv); else n_pass++;
        n_checks++; if ({dut.state_r, mem_req} !== {IDLE, 1'b0}) $display("FAIL rstmid_idle: got %h want %h", {dut.state_r, mem_req}, {IDLE, 1'b0}); else n_pass++;
    endtask

    task automatic test_random();
        localparam int N = 600;
        bit          f_pend, d_pend, d_we_m, prev_req, prev_ack, done;
        int          f_start, d_start, tk;
        logic [31:0] f_a, d_a, d_w;
        logic [3:0]  d_b;
        logic [68:0] prev_pl;
        f_pend = 1'b0; d_pend = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; done = 1'b0;
        f_start = 0; d_start = 0; f_a = 32'h1000; d_a = 32'h2000; d_w = '0; d_b = 4'h0; d_we_m = 1'b0;
        prev_pl = '0;
        slave_rand = 1'b1;
        for (tk = 1; tk <= N + 200; tk++) begin
            tick();
            n_checks++; if (f_stall !== (if_req & ~if_valid)) $display("FAIL rnd_f_stall t=%0d: got %b want %b", tk, f_stall, if_req & ~if_valid); else n_pass++;
            n_checks++; if (m_stall !== (dm_req & ~dm_valid)) $display("FAIL rnd_m_stall t=%0d: got %b want %b", tk, m_stall, dm_req & ~dm_valid); else n_pass++;
            if (prev_req && !prev_ack) begin
                n_checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, prev_pl}) $display("FAIL rnd_req_stable t=%0d: got %h want %h", tk, {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, {1'b1, prev_pl}); else n_pass++;
            end
            if (if_valid) begin
                n_checks++; if (f_pend !== 1'b1) $display("FAIL rnd_spurious_if_valid t=%0d: got 1 want 0", tk); else n_pass++;
                if (f_pend) begin
                    n_checks++; if (if_rdata !== ref_read(f_a)) $display("FAIL rnd_if_rdata t=%0d: got %h want %h", tk, if_rdata, ref_read(f_a)); else n_pass++;
                    n_checks++; if (tk - f_start < 2) $display("FAIL rnd_if_latency t=%0d: got %0d want >=2", tk, tk - f_start); else n_pass++;
                end
                f_pend = 1'b0; if_req = 1'b0;
            end
            if (dm_valid) begin
                n_checks++; if (d_pend !== 1'b1) $display("FAIL rnd_spurious_dm_valid t=%0d: got 1 want 0", tk); else n_pass++;
                if (d_pend && d_we_m) ref_mem[d_a] = merge(ref_read(d_a), d_w, d_b);
                if (d_pend && !d_we_m) begin
                    n_checks++; if (dm_rdata !== ref_read(d_a)) $display("FAIL rnd_dm_rdata t=%0d: got %h want %h", tk, dm_rdata, ref_read(d_a)); else n_pass++;
                end
                if (d_pend) begin
                    n_checks++; if (tk - d_start < 2) $display("FAIL rnd_dm_latency t=%0d: got %0d want >=2", tk, tk - d_start); else n_pass++;
                end
                d_pend = 1'b0; dm_req = 1'b0;
            end
            if (f_pend && tk - f_start > 80) begin
                n_checks++; $display("FAIL rnd_fetch_timeout t=%0d: waited %0d want <=80", tk, tk - f_start);
                f_pend = 1'b0; if_req = 1'b0;
            end
            if (d_pend && tk - d_start > 80) begin
                n_checks++; $display("FAIL rnd_data_timeout t=%0d: waited %0d want <=80", tk, tk - d_start);
                d_pend = 1'b0; dm_req = 1'b0;
            end
            prev_req = mem_req; prev_ack = mem_ack;
            prev_pl  = {mem_we, mem_addr, mem_wdata, mem_be};
            if (tk >= N && !f_pend && !d_pend) begin
                done = 1'b1;
                break;
            end
            if_kill = 1'b0;
            if (tk < N && f_pend && ($urandom_range(7, 0) == 0)) begin
                if_kill = 1'b1; if_req = 1'b0; f_pend = 1'b0;
            end else if (tk < N && !f_pend && ($urandom_range(2, 0) == 0)) begin
                f_a = f_a + 32'(4 * $urandom_range(15, 1));
                if_addr = f_a; if_req = 1'b1; f_pend = 1'b1; f_start = tk;
            end
            if (tk < N && !d_pend && ($urandom_range(2, 0) == 0)) begin
                d_we_m = 1'($urandom_range(1, 0));
                d_a    = 32'h2000 + 32'(4 * $urandom_range(7, 0));
                d_w    = $urandom;
                d_b    = 4'($urandom_range(15, 1));
                dm_we = d_we_m; dm_addr = d_a; dm_wdata = d_w; dm_be = d_b;
                dm_req = 1'b1; d_pend = 1'b1; d_start = tk;
            end
        end
        if_kill = 1'b0;
        n_checks++; if (done !== 1'b1) $display("FAIL rnd_drain: got %b want 1", done); else n_pass++;
        slave_rand = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_kill();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
